// File: rtl/riscv_debug_host.sv
// riscv_debug_host: host-side bridge to a core debug bus with one outstanding
// transaction, alignment check and a bounded wait for the core's response.
`default_nettype none

module riscv_debug_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [14:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        debug_req_o,
  input  logic        debug_gnt_i,
  input  logic        debug_rvalid_i,
  output logic [14:0] debug_addr_o,
  output logic        debug_we_o,
  output logic [31:0] debug_wdata_o,
  input  logic [31:0] debug_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RV = 2'd2,
    S_RSP     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_inc;
  logic        timeout;

  // Saturating increment; timeout fires on the cycle the count would hit the limit.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout = ({16'd0, cnt_q} + 32'd1) >= TIMEOUT_CYCLES;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          cnt_d   = '0;
          if (cmd_addr_i[1:0] != 2'b00) begin
            state_d = S_RSP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (debug_gnt_i) begin
          state_d = S_WAIT_RV;
        end else if (timeout) begin
          state_d = S_RSP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT_RV: begin
        cnt_d = cnt_inc;
        if (debug_rvalid_i) begin
          state_d = S_RSP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : debug_rdata_i;
        end else if (timeout) begin
          state_d = S_RSP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = (state_q == S_RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign debug_req_o   = (state_q == S_REQ);
  assign debug_addr_o  = addr_q;
  assign debug_we_o    = we_q;
  assign debug_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: doc/riscv_debug_host.md
RISCV_DEBUG_HOST -- requirements
Module: riscv_debug_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles from debug_req_o assertion to debug_rvalid_i before abort; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid_i  input  1  host command valid.
REQ-005 SHALL have port cmd_ready_o  output  1  block can accept a command.
REQ-006 SHALL have port cmd_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr_i  input  15  debug byte address (e.g. 0x3010 = DMR1).
REQ-008 SHALL have port cmd_wdata_i  input  32  write data.
REQ-009 SHALL have port rsp_valid_o  output  1  response valid.
REQ-010 SHALL have port rsp_ready_i  input  1  host accepts response.
REQ-011 SHALL have port rsp_rdata_o  output  32  read data (0 for writes and errors).
REQ-012 SHALL have port rsp_err_o  output  1  1 = misaligned or timed out.
REQ-013 SHALL have port debug_req_o  output  1  request to core debug unit.
REQ-014 SHALL have port debug_gnt_i  input  1  core grants request.
REQ-015 SHALL have port debug_rvalid_i  input  1  core response valid.
REQ-016 SHALL have ports debug_addr_o (output, 15), debug_we_o (output, 1), debug_wdata_o (output, 32), debug_rdata_i (input, 32): core debug bus.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT_RV, RSP; one transaction outstanding at most.
REQ-018 SHALL drive cmd_ready_o = 1 only in IDLE; a command is accepted when cmd_valid_i & cmd_ready_o.
REQ-019 SHALL latch we/addr/wdata on acceptance; debug_addr_o/we_o/wdata_o hold the latched values, stable from REQ entry until RSP exit.
REQ-020 SHALL, on accepting a command with cmd_addr_i[1:0] != 0, go IDLE->RSP with rsp_err_o=1, rsp_rdata_o=0, and no debug_req_o pulse.
REQ-021 SHALL, on accepting an aligned command, enter REQ the next cycle and drive debug_req_o = 1 exactly while in REQ.
REQ-022 SHALL, in REQ with debug_gnt_i=1, go to WAIT_RV; debug_req_o is low in the following cycle.
REQ-023 SHALL sample debug_rvalid_i only in WAIT_RV; when it is 1, capture debug_rdata_i (reads) or 0 (writes) and enter RSP with rsp_err_o=0.
REQ-024 SHALL ignore debug_rvalid_i in IDLE, REQ and RSP (a late response after timeout is dropped).
REQ-025 SHALL run a 16-bit timeout counter, cleared on REQ entry, incremented each cycle in REQ or WAIT_RV; when it reaches TIMEOUT_CYCLES without completion, enter RSP with rsp_err_o=1, rsp_rdata_o=0.
REQ-026 SHALL give gnt/rvalid priority over timeout when both occur in the same cycle.
REQ-027 SHALL assert rsp_valid_o only in RSP, holding rsp_rdata_o/rsp_err_o stable until rsp_valid_o & rsp_ready_i, then return to IDLE.
REQ-028 SHALL give a minimum latency of 3 cycles from accept to rsp_valid_o (gnt in first REQ cycle, rvalid in next cycle); rsp_valid_o is registered.
REQ-029 SHALL allow a new command to be accepted in the cycle after the response handshake (IDLE), not in the same cycle.

Reset
REQ-030 SHALL, with rst_n=0 at a rising edge, go to IDLE, clear the counter and latches, and drive cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, debug_req_o=0, debug_we_o=0, debug_addr_o=0, debug_wdata_o=0.
REQ-031 SHALL abort any in-flight transaction on reset, producing no response, including mid REQ/WAIT_RV.

Verification
REQ-032 Read 0x3010, gnt in cycle 1, rvalid+rdata 0xDEADBEEF in cycle 2 -> rsp_valid_o in cycle 3, rdata 0xDEADBEEF, err 0.
REQ-033 Write 0x3000 data 0x12345678, gnt delayed 5 cycles -> debug_req_o high 6 cycles with stable addr/data, rsp err 0, rdata 0.
REQ-034 Read 0x3011 (misaligned) -> no debug_req_o, rsp err 1 within 2 cycles.
REQ-035 TIMEOUT_CYCLES=8, no gnt -> rsp err 1 after 8 counted cycles; late rvalid afterwards ignored; next command completes normally.
REQ-036 rsp_ready_i low 4 cycles -> rsp held stable, cmd_ready_o 0 throughout.
REQ-037 rst_n low during WAIT_RV -> next cycle IDLE, all outputs at reset values, no rsp_valid_o.
